// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - instruction prefetch FIFO between fetch and decode
module inst_queue #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              if_valid,
   input  logic [PC_W-1:0]   if_pc,
   input  logic [INST_W-1:0] if_inst,
   output logic              if_ready,
   output logic              id_valid,
   output logic [PC_W-1:0]   id_pc,
   output logic [INST_W-1:0] id_inst,
   input  logic              id_ready,
   output logic [CNT_W-1:0]  count
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PC_W-1:0]   pc_mem_q   [DEPTH];
   logic [INST_W-1:0] inst_mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic push;
   logic pop;

   // if_ready looks only at registered occupancy and flush, so decode's
   // id_ready never reaches the fetch side combinationally.
   assign if_ready = rstn && (count_q != FULL_CNT) && !flush;
   assign id_valid = (count_q != '0);
   assign push     = if_valid && if_ready;
   assign pop      = id_valid && id_ready;
   assign count    = count_q;

   // Head is first-word-fall-through; an empty queue presents a NOP of zeros.
   assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q]   : '0;
   assign id_inst  = id_valid ? inst_mem_q[rd_ptr_q] : '0;

   // Pointer and occupancy next state; flush wins over any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control registers; reset takes priority over everything else.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; zeroed at reset so the head mux never sees X.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]   <= if_pc;
         inst_mem_q[wr_ptr_q] <= if_inst;
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - self-checking bench for inst_queue
module tb_inst_queue;

   logic        clk;
   logic        rstn;
   logic        flush;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_ready;
   logic [2:0]  count;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t sb[$];
   int   n_checks;
   int   n_fail;

   inst_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .CNT_W(3)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (flush),
      .if_valid (if_valid),
      .if_pc    (if_pc),
      .if_inst  (if_inst),
      .if_ready (if_ready),
      .id_valid (id_valid),
      .id_pc    (id_pc),
      .id_inst  (id_inst),
      .id_ready (id_ready),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge and update the scoreboard from the bench's own
   // view of what the queue should have accepted and released.
   task automatic tick();
      bit   m_push;
      bit   m_pop;
      ent_t e;
      m_push = if_valid && rstn && !flush && (sb.size() != 4);
      m_pop  = id_ready && (sb.size() != 0);
      e.pc   = if_pc;
      e.inst = if_inst;
      @(posedge clk);
      #1;
      if (!rstn || flush) begin
         sb.delete();
      end else begin
         if (m_pop)  void'(sb.pop_front());
         if (m_push) sb.push_back(e);
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst, input bit rdy);
      if_valid = v;
      if_pc    = pc;
      if_inst  = inst;
      id_ready = rdy;
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; flush = 1'b0;
      drive(1'b1, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (if_ready !== 1'b0) begin n_fail++; $display("FAIL reset_if_ready_low: got %b expected 0", if_ready); end
      tick();
      tick();
      rstn = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready_rel: got %b expected 1", if_ready); end
      n_checks++;
      if (id_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL reset_state: got valid=%b count=%0d expected 0/0", id_valid, count); end
      n_checks++;
      if (id_pc !== 32'h0 || id_inst !== 32'h0) begin n_fail++; $display("FAIL reset_head: got pc=%h inst=%h expected 0/0", id_pc, id_inst); end
   endtask

   task automatic test_fill();
      logic [31:0] insts [3];
      insts[0] = 32'h34010001; insts[1] = 32'h34020002; insts[2] = 32'h34030003;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'(i * 4), insts[i], 1'b0);
         n_checks++;
         if (if_ready !== 1'b1) begin n_fail++; $display("FAIL fill_if_ready[%0d]: got %b expected 1", i, if_ready); end
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (count !== 3'd3 || id_valid !== 1'b1) begin n_fail++; $display("FAIL fill_count: got count=%0d valid=%b expected 3/1", count, id_valid); end
      n_checks++;
      if (id_pc !== 32'h0 || id_inst !== 32'h34010001) begin n_fail++; $display("FAIL fill_head: got pc=%h inst=%h expected 0/34010001", id_pc, id_inst); end
   endtask

   task automatic test_full();
      drive(1'b1, 32'h0C, 32'h34040004, 1'b0);
      tick();
      drive(1'b1, 32'h10, 32'h34050005, 1'b0);
      n_checks++;
      if (if_ready !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL full_block: got ready=%b count=%0d expected 0/4", if_ready, count); end
      tick();
      drive(1'b1, 32'h10, 32'h34050005, 1'b1);
      n_checks++;
      if (count !== 3'd4 || if_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold: got count=%0d ready=%b expected 4/0", count, if_ready); end
      n_checks++;
      if (id_pc !== 32'h0) begin n_fail++; $display("FAIL full_pop_head: got %h expected 0", id_pc); end
      tick();
      drive(1'b1, 32'h10, 32'h34050005, 1'b0);
      n_checks++;
      if (count !== 3'd3 || if_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop: got count=%0d ready=%b expected 3/1", count, if_ready); end
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      n_checks++;
      if (count !== 3'd4) begin n_fail++; $display("FAIL full_accept: got %0d expected 4", count); end
      for (int i = 0; i < 8 && sb.size() != 0; i++) begin
         n_checks++;
         if (id_valid !== 1'b1 || id_pc !== sb[0].pc || id_inst !== sb[0].inst)
            begin n_fail++; $display("FAIL full_drain[%0d]: got v=%b pc=%h inst=%h expected 1/%h/%h", i, id_valid, id_pc, id_inst, sb[0].pc, sb[0].inst); end
         tick();
      end
      n_checks++;
      if (id_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL full_drained: got v=%b count=%0d expected 0/0", id_valid, count); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'(i * 4), 32'h34000000 | 32'(i), 1'b1);
         if (i > 0) begin
            n_checks++;
            if (count !== 3'd1 || id_valid !== 1'b1) begin n_fail++; $display("FAIL stream_count[%0d]: got count=%0d v=%b expected 1/1", i, count, id_valid); end
            n_checks++;
            if (id_pc !== 32'((i - 1) * 4) || id_pc !== sb[0].pc || id_inst !== sb[0].inst)
               begin n_fail++; $display("FAIL stream_order[%0d]: got pc=%h inst=%h expected %h/%h", i, id_pc, id_inst, (i - 1) * 4, sb[0].inst); end
         end
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      n_checks++;
      if (id_pc !== 32'h24 || id_inst !== 32'h34000009) begin n_fail++; $display("FAIL stream_last: got pc=%h inst=%h expected 24/34000009", id_pc, id_inst); end
      tick();
      n_checks++;
      if (count !== 3'd0 || sb.size() != 0) begin n_fail++; $display("FAIL stream_empty: got count=%0d expected 0", count); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h30 + 32'(i * 4), 32'h35000000 | 32'(i), 1'b0);
         tick();
      end
      flush = 1'b1;
      drive(1'b1, 32'h40, 32'h34400040, 1'b0);
      n_checks++;
      if (count !== 3'd3 || if_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre: got count=%0d ready=%b expected 3/0", count, if_ready); end
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      n_checks++;
      if (count !== 3'd0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state: got count=%0d v=%b ready=%b expected 0/0/1", count, id_valid, if_ready); end
      n_checks++;
      if (id_pc !== 32'h0 || id_inst !== 32'h0) begin n_fail++; $display("FAIL flush_head: got pc=%h inst=%h expected 0/0", id_pc, id_inst); end
      tick();
      n_checks++;
      if (id_valid !== 1'b0 || id_pc === 32'h40) begin n_fail++; $display("FAIL flush_discard: got v=%b pc=%h expected 0/0", id_valid, id_pc); end
   endtask

   task automatic test_empty_latency();
      drive(1'b1, 32'h20, 32'h34200020, 1'b1);
      n_checks++;
      if (id_valid !== 1'b0 || id_pc !== 32'h0) begin n_fail++; $display("FAIL empty_nobypass: got v=%b pc=%h expected 0/0", id_valid, id_pc); end
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h20 || id_inst !== 32'h34200020 || sb.size() != 1)
         begin n_fail++; $display("FAIL empty_latency: got v=%b pc=%h inst=%h expected 1/20/34200020", id_valid, id_pc, id_inst); end
      tick();
      n_checks++;
      if (count !== 3'd0) begin n_fail++; $display("FAIL empty_popped: got %0d expected 0", count); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h60 + 32'(i * 4), 32'h36000000 | 32'(i), 1'b0);
         tick();
      end
      n_checks++;
      if (count !== 3'd2) begin n_fail++; $display("FAIL rmid_pre: got %0d expected 2", count); end
      rstn = 1'b0; flush = 1'b0;
      drive(1'b1, 32'h50, 32'h34500050, 1'b0);
      n_checks++;
      if (if_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got %b expected 0", if_ready); end
      tick();
      rstn = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (count !== 3'd0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_post: got count=%0d v=%b ready=%b expected 0/0/1", count, id_valid, if_ready); end
      n_checks++;
      if (id_pc !== 32'h0 || id_inst !== 32'h0) begin n_fail++; $display("FAIL rmid_head: got pc=%h inst=%h expected 0/0", id_pc, id_inst); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rstn     = 1'b0;
      flush    = 1'b0;
      if_valid = 1'b0;
      if_pc    = '0;
      if_inst  = '0;
      id_ready = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_fill();
      test_full();
      test_back_to_back();
      test_flush();
      test_empty_latency();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction prefetch queue between the fetch stage (PC register + instruction ROM) and the decode stage.
- Buffers fetched {pc, instruction} pairs in a small FIFO with valid/ready handshakes on both sides, so fetch can run ahead while decode stalls.
- Supports a synchronous flush for branch redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PC_W, 32, width of the stored PC tag.
- INST_W, 32, instruction width.
- CNT_W, 3, width of the occupancy counter; must equal clog2(DEPTH+1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rstn  input  1  synchronous active-low reset.
- flush  input  1  discard all queued entries (branch redirect).
- if_valid  input  1  fetch presents a valid entry.
- if_pc  input  PC_W  PC of the presented instruction.
- if_inst  input  INST_W  presented instruction word.
- if_ready  output  1  queue can accept an entry this cycle.
- id_valid  output  1  head entry valid toward decode.
- id_pc  output  PC_W  PC of the head entry.
- id_inst  output  INST_W  instruction of the head entry.
- id_ready  input  1  decode consumes the head this cycle.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry register array holding {pc, inst}, with wr_ptr, rd_ptr (log2(DEPTH) bits, natural wrap at DEPTH) and a count register.
- Push: occurs when if_valid && if_ready. Writes mem[wr_ptr], then wr_ptr+1.
- Pop: occurs when id_valid && id_ready. Advances rd_ptr+1.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- if_ready = rstn && (count != DEPTH) && !flush.
  - Depends on registered state plus flush only.
  - No combinational path from id_ready to if_ready; no bypass when full.
- id_valid = (count != 0).
- Head outputs are first-word-fall-through from mem[rd_ptr].
  - When count == 0, id_pc and id_inst drive all zeros (NOP).
- Latency: an entry pushed at edge N is visible on id_* after edge N (one cycle). No same-cycle input-to-output bypass when empty.
- Full (count == DEPTH): if_ready = 0 and the push is ignored even if id_ready = 1 that cycle. Pop proceeds, and if_ready rises the next cycle.
- Empty: id_valid = 0. id_ready is ignored and no pointer moves.
- Wrap-around: the pointers wrap modulo DEPTH. Ordering is strictly FIFO across the wrap.
- Flush: synchronous; at the edge with flush = 1, wr_ptr, rd_ptr and count are set to 0.
  - A push or pop in the same cycle is discarded.
  - Flush has priority over push and pop.
  - Array contents need not be cleared.
  - In the cycle after the flush, id_valid = 0 and if_ready = 1.
- Reset: at a rising edge with rstn = 0, the pointers and count go to 0.
  - Outputs then read: id_valid = 0, id_pc = 0, id_inst = 0, count = 0.
  - if_ready = 0 while rstn is low, and 1 in the first cycle after release.
  - Reset has priority over flush.
  - Reset mid-operation drops all entries.
- Priority order: reset > flush > push/pop.
- No X propagation: the array is zeroed at reset so that the head is never X.

Test Plan:
- Reset, then push PCs 0x00, 0x04, 0x08 with if_inst = 0x34010001, 0x34020002, 0x34030003 and id_ready = 0 -> count = 3; id_valid = 1; id_pc = 0x00, id_inst = 0x34010001.
- Fill to 4, keep if_valid = 1 with PC 0x10 -> if_ready = 0, count stays 4; raise id_ready for one cycle -> pops 0x00, count = 3, and 0x10 is accepted the next cycle.
- Stream 10 entries (PC 0x00..0x24) with if_valid = 1 and id_ready = 1 continuously -> count holds at 1 after the first cycle; decode sees PCs in order across two pointer wraps; no gaps after first latency.
- With count = 3, assert flush together with a push of PC 0x40 -> next cycle count = 0, id_valid = 0, id_pc = 0, id_inst = 0; 0x40 is never output.
- Empty queue, id_ready = 1, if_valid = 1 PC 0x20 -> id_valid = 0 that cycle; the next cycle id_valid = 1 with id_pc = 0x20.
- With count = 2, drive rstn = 0 for one edge while flush = 0 and if_valid = 1 -> if_ready = 0 during reset; afterwards count = 0, id_valid = 0, if_ready = 1.
